// File: rtl/cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state
// encoding and the one-hot {gt, lt, eq} result encoding.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result flags packed as {gt, lt, eq}; exactly one bit set.
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    // Map the final decided/gt registers onto the one-hot result.
    // An undecided comparison means every bit matched.
    function automatic logic [2:0] encode_result(input logic decided, input logic gt);
        if (!decided) begin
            encode_result = CMP_EQ;
        end else if (gt) begin
            encode_result = CMP_GT;
        end else begin
            encode_result = CMP_LT;
        end
    endfunction

endpackage

// File: rtl/cmp_bit_step.sv
// One MSB-first comparison step. The first differing bit decides the
// result; once decided, the result is sticky and later bits are ignored.
module cmp_bit_step (
    input  logic decided_in,
    input  logic gt_in,
    input  logic lt_in,
    input  logic a_bit,
    input  logic b_bit,
    output logic decided_out,
    output logic gt_out,
    output logic lt_out
);

    // Latch the first difference, otherwise pass the running state through.
    always_comb begin
        decided_out = decided_in;
        gt_out      = gt_in;
        lt_out      = lt_in;
        if (!decided_in && (a_bit != b_bit)) begin
            decided_out = 1'b1;
            gt_out      = a_bit & ~b_bit;
            lt_out      = ~a_bit & b_bit;
        end
    end

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator with valid/ready on both sides.
// Operands are shifted out MSB first, one bit per clock.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready/busy/out_valid are decoded from registered state only,
// so there is no combinational path from in_valid or out_ready.
//
// Build option SERIAL_CMP_EARLY_EXIT_EN: when defined, CMP exits to DONE on
// the edge that finds the first differing bit; otherwise every pair takes
// exactly N compare cycles. Result flags are the same either way.
module serial_comparator
    import cmp_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         a_gt_b,
    output logic         a_lt_b,
    output logic         a_eq_b,
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t          state_q,   state_d;
    logic [N-1:0]    sa_q,      sa_d;
    logic [N-1:0]    sb_q,      sb_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic            decided_q, decided_d;
    logic            gt_q,      gt_d;
    logic            lt_q,      lt_d;
    logic [2:0]      flags_q,   flags_d;

    logic            step_decided;
    logic            step_gt;
    logic            step_lt;
    logic            finish;

    cmp_bit_step u_step (
        .decided_in  (decided_q),
        .gt_in       (gt_q),
        .lt_in       (lt_q),
        .a_bit       (sa_q[N-1]),
        .b_bit       (sb_q[N-1]),
        .decided_out (step_decided),
        .gt_out      (step_gt),
        .lt_out      (step_lt)
    );

    // Decide when the compare phase ends: last bit, or first difference
    // when early exit is built in.
    always_comb begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        finish = (cnt_q == '0) || step_decided;
`else
        finish = (cnt_q == '0);
`endif
    end

    // Next-state and datapath update for the IDLE -> CMP -> DONE loop.
    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        flags_d   = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d      = a;
                    sb_d      = b;
                    cnt_d     = CW'(N - 1);
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                    state_d   = CMP;
                end
            end
            CMP: begin
                decided_d = step_decided;
                gt_d      = step_gt;
                lt_d      = step_lt;
                sa_d      = sa_q << 1;
                sb_d      = sb_q << 1;
                cnt_d     = cnt_q - CW'(1);
                if (finish) begin
                    state_d = DONE;
                    flags_d = encode_result(step_decided, step_gt);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    flags_d = 3'b000;
                end
            end
            default: begin
                state_d = IDLE;
                flags_d = 3'b000;
            end
        endcase
    end

    // State and datapath registers; reset aborts any comparison in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            flags_q   <= 3'b000;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            flags_q   <= flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign a_gt_b    = |(flags_q & CMP_GT);
    assign a_lt_b    = |(flags_q & CMP_LT);
    assign a_eq_b    = |(flags_q & CMP_EQ);

endmodule

// File: tb/tb_serial_comparator.sv
// Testbench for serial_comparator: directed cases plus random operand
// pairs, checked against a plain-arithmetic reference model.
module tb_serial_comparator;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic         a_gt_b;
  logic         a_lt_b;
  logic         a_eq_b;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2:0] exp_q[$];
  int         lat_q[$];

  serial_comparator #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_gt_b    (a_gt_b),
    .a_lt_b    (a_lt_b),
    .a_eq_b    (a_eq_b),
    .busy      (busy)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_flags(input int x, input int y);
    if (x > y) return 3'b100;
    if (x < y) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_lat(input int x, input int y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    if (x != y) begin
      for (int i = N - 1; i >= 0; i--) begin
        if ((((x ^ y) >> i) & 1) == 1) return N - i;
      end
    end
`endif
    return N;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Random traffic on ignored inputs while the block is busy.
  task automatic drive_noise();
    in_valid  = 1'($urandom_range(0, 1));
    a         = N'($urandom);
    b         = N'($urandom);
    out_ready = 1'($urandom_range(0, 1));
  endtask

  // Called right after the accepting edge.
  task automatic post_accept(input logic [N-1:0] pa, input logic [N-1:0] pb);
    exp_q.push_back(model_flags(int'(pa), int'(pb)));
    lat_q.push_back(model_lat(int'(pa), int'(pb)));
    @(negedge clk);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    check("in_ready_after_accept", {31'b0, in_ready}, 32'd0);
    drive_noise();
  endtask

  task automatic accept_pair(input logic [N-1:0] pa, input logic [N-1:0] pb);
    @(negedge clk);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    a         = pa;
    b         = pb;
    out_ready = 1'b0;
    @(posedge clk);
    post_accept(pa, pb);
  endtask

  // Count edges from accept until out_valid, then check latency and flags.
  task automatic wait_result();
    int lat;
    int exp_lat;
    lat = 0;
    exp_lat = lat_q.pop_front();
    while (!out_valid && lat < 4 * N + 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!out_valid) drive_noise();
    end
    check("latency", lat, exp_lat);
    check("flags", {29'b0, a_gt_b, a_lt_b, a_eq_b}, {29'b0, exp_q[0]});
  endtask

  // Hold off the consumer, then complete the output handshake.
  task automatic finish_pair(input int hold, input bit btb,
                             input logic [N-1:0] na, input logic [N-1:0] nb);
    logic [2:0] cur;
    cur = exp_q.pop_front();
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = N'($urandom);
      b         = N'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_flags", {29'b0, a_gt_b, a_lt_b, a_eq_b}, {29'b0, cur});
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = btb;
    a         = na;
    b         = nb;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", {31'b0, out_valid}, 32'd0);
    check("release_flags", {29'b0, a_gt_b, a_lt_b, a_eq_b}, 32'd0);
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    check("release_busy", {31'b0, busy}, 32'd0);
    if (btb) begin
      @(posedge clk);
      post_accept(na, nb);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_flags"}, {29'b0, a_gt_b, a_lt_b, a_eq_b}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // equal operands
    accept_pair(4'b0101, 4'b0101);
    wait_result();
    finish_pair(0, 1'b0, '0, '0);

    // greater, with backpressure
    accept_pair(4'b0110, 4'b0011);
    wait_result();
    finish_pair(3, 1'b0, '0, '0);

    // less
    accept_pair(4'b0010, 4'b0111);
    wait_result();
    finish_pair(1, 1'b0, '0, '0);

    // extremes, back to back
    accept_pair(4'b1111, 4'b0000);
    wait_result();
    finish_pair(0, 1'b1, 4'b0000, 4'b1111);
    wait_result();
    finish_pair(2, 1'b0, '0, '0);

    // abort two cycles into the compare
    accept_pair(4'b1000, 4'b0111);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("reset_hold_out_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_out_valid", {31'b0, out_valid}, 32'd0);

    accept_pair(4'b0001, 4'b0010);
    wait_result();
    finish_pair(0, 1'b0, '0, '0);

    // random pairs
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = N'($urandom_range(0, (1 << N) - 1));
      rb = (i % 4 == 0) ? ra : N'($urandom_range(0, (1 << N) - 1));
      accept_pair(ra, rb);
      wait_result();
      finish_pair($urandom_range(0, 2), 1'b0, '0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
Name: serial_comparator

Overview:
- Bit-serial, handshaked magnitude comparator. It is the sequential counterpart of the parallel n_bit_comparator.
- Accepts an unsigned operand pair A/B on a valid/ready input port.
- Compares one bit per clock, MSB first.
- Returns one-hot GT/LT/EQ flags on a valid/ready output port.
- Used where operands arrive from a streaming source and area matters more than latency.

Parameters:
- N, 4, operand width in bits; N >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair on a/b is valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  N  operand A, unsigned.
- b  in  N  operand B, unsigned.
- out_valid  out  1  result flags valid.
- out_ready  in  1  consumer accepts the result.
- a_gt_b  out  1  A > B.
- a_lt_b  out  1  A < B.
- a_eq_b  out  1  A == B.
- busy  out  1  high in CMP or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- State machine: IDLE -> CMP -> DONE -> IDLE.
- Reset (asynchronous): state=IDLE; a_gt_b=a_lt_b=a_eq_b=0; out_valid=0; busy=0; in_ready=1. Shift registers and counter clear to 0.
- in_ready = (state==IDLE), decoded from registered state only. No combinational path from in_valid or out_ready.
- Input accept: on an edge with in_valid && in_ready:
  - latch a and b into shift registers;
  - clear the internal decided/gt/lt registers;
  - bit counter = N-1;
  - go to CMP.
- in_valid while not in IDLE is ignored; a/b are not sampled.
- CMP, each edge:
  - Compare sa[N-1] with sb[N-1].
  - If nothing is decided yet and the bits differ: set decided, set gt = sa[N-1]&~sb[N-1], set lt = the inverse case.
  - Once decided, the result is sticky.
  - Shift both registers left by 1 and decrement the counter.
  - On the edge that processes counter==0: go to DONE and register the flags.
  - eq = ~decided.
- Flags are exactly one-hot whenever out_valid=1.
- Latency:
  - If the accept is at edge t, out_valid rises after edge t+N.
  - N=1 gives out_valid after edge t+1.
- DONE:
  - out_valid=1; flags held stable until the handshake.
  - On an edge with out_ready=1: go to IDLE, out_valid=0, flags cleared to 0.
  - Throughput: one pair per N+2 cycles minimum, because the bubble in IDLE is mandatory.
- out_ready while not in DONE has no effect.
- Reset during CMP or DONE: aborts immediately. No result is emitted and all outputs take their reset values.
- Counter width: max(1, $clog2(N)).

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: CMP exits to DONE on the edge where the first differing bit is found.
  - If the first difference is at bit position p (MSB = N-1), out_valid rises after edge t+(N-p).
  - Equal operands still take N cycles.
- Not defined: fixed N-cycle latency for every operand pair.
- Flag values are identical in both builds.

Decomposition:
- Package cmp_pkg holds:
  - state typedef (enum IDLE, CMP, DONE);
  - result encoding constants (CMP_GT, CMP_LT, CMP_EQ as a 3-bit one-hot).
- Sub-module cmp_bit_step, combinational:
  - inputs: decided_in, gt_in, lt_in, a_bit, b_bit;
  - outputs: decided_out, gt_out, lt_out.
  - Instantiated once; it is the per-cycle update.

Test Plan:
- Reset: hold rst_n=0 mid-sim -> out_valid=0, all flags 0, busy=0, in_ready=1 immediately (asynchronous, not waiting for an edge).
- A=0101, B=0101 -> a_eq_b=1, gt=lt=0; out_valid exactly 4 cycles after accept in both builds.
- A=0110, B=0011 -> a_gt_b=1; 4 cycles by default, 2 cycles with SERIAL_CMP_EARLY_EXIT_EN. Also A=0010, B=0111 -> a_lt_b=1 with the same latencies.
- A=1111, B=0000 -> gt; A=0000, B=1111 -> lt; early-exit build gives 1 cycle. Back-to-back in_valid -> second pair is accepted only after the out handshake plus the IDLE cycle.
- Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid and flags stable; new a/b with in_valid=1 are ignored; out_ready=1 -> IDLE next edge.
- Reset asserted 2 cycles into CMP with A=1000, B=0111 -> no out_valid. After release, a fresh pair A=0001, B=0010 -> a_lt_b=1.
